reg_file_param: RTL

Parametrised successor to the 32x32 MIPS register file. It has a configurable data width, register count and number of read ports, an optional hardwired-zero register, and optional write-to-read bypass. It also contains a per-register pending-write scoreboard (busy bits) for multi-cycle producers such as loads. It sits in the decode stage of the MIPS datapath: hazard logic reads the busy flags, and the writeback stage drives the write port.

---
 rtl/mips_pkg.sv | 13 +
 rtl/reg_wr_decoder.sv | 16 +
 rtl/reg_file_param.sv | 68 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file defaults, zero-register index and AW sizing helper
package mips_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW = 5;
  localparam int ZERO_IDX = 0;
  function automatic int clog2_nreg(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/reg_wr_decoder.sv
// reg_wr_decoder: enable-gated AW-to-NREG one-hot decoder
//   adr_i : address to decode; codes >= NREG select nothing
//   en_i  : enable; all outputs low when deasserted
//   sel_o : one-hot select, bit i high when en_i and adr_i == i
module reg_wr_decoder #(
  parameter int AW = 5,
  parameter int NREG = 32
) (
  input  logic [AW-1:0]   adr_i,
  input  logic            en_i,
  output logic [NREG-1:0] sel_o
);
  for (genvar i = 0; i < NREG; i++) begin : g_sel
    assign sel_o[i] = en_i && adr_i == AW'(i);
  end
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-port register file with bypass and pending-write scoreboard
//   Clk, Rst  : clock and asynchronous active-high reset
//   Ard/Dout  : NRD combinational read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   Busy      : per read port, addressed register has a pending write
//   Awr/Din/WrEn : write port; a write also retires the register's pending flag
//   SbSet/SbAdr  : mark a register pending when its producer issues
module reg_file_param
  import mips_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW = DEF_AW,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NRD*AW-1:0] Ard,
  output logic [NRD*DW-1:0] Dout,
  output logic [NRD-1:0]    Busy,
  input  logic [AW-1:0]     Awr,
  input  logic [DW-1:0]     Din,
  input  logic              WrEn,
  input  logic              SbSet,
  input  logic [AW-1:0]     SbAdr
);
  if (AW < clog2_nreg(NREG)) begin : g_aw_chk
    $fatal(1, "reg_file_param: AW too narrow for NREG");
  end
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d, we_dec, sb_dec, wr_v, sb_v;
  reg_wr_decoder #(.AW(AW), .NREG(NREG)) u_we_dec (.adr_i(Awr), .en_i(WrEn), .sel_o(we_dec));
  reg_wr_decoder #(.AW(AW), .NREG(NREG)) u_sb_dec (.adr_i(SbAdr), .en_i(SbSet), .sel_o(sb_dec));
  // the zero register never takes data or a pending flag; a write still retires busy
  // via we_dec, and set is OR-ed last so a same-cycle reissue wins over retirement
  always_comb begin
    wr_v = we_dec;
    sb_v = sb_dec;
    if (ZERO_REG != 0) begin
      wr_v[ZERO_IDX] = 1'b0;
      sb_v[ZERO_IDX] = 1'b0;
    end
    busy_d = sb_v | (busy_q & ~we_dec);
    for (int i = 0; i < NREG; i++) regs_d[i] = wr_v[i] ? Din : regs_q[i];
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  // read mux by compare-and-select so out-of-range codes fall through to 0;
  // wr_v[i] already encodes a valid, unsuppressed write to this register
  always_comb begin
    Dout = '0;
    Busy = '0;
    for (int k = 0; k < NRD; k++)
      for (int i = 0; i < NREG; i++)
        if (!Rst && Ard[k*AW +: AW] == AW'(i) && !(ZERO_REG != 0 && i == ZERO_IDX)) begin
          Dout[k*DW +: DW] = (BYPASS != 0 && wr_v[i]) ? Din : regs_q[i];
          Busy[k] = busy_q[i] && !(BYPASS != 0 && wr_v[i]);
        end
  end
endmodule
